// File: rtl/freelist_release_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : freelist_release_queue                                        |
// | Purpose  : Return path of the free-list. Captures per-lane release       |
// |            requests with their iteration tags, grants one pending lane   |
// |            per cycle into a small FIFO, and presents {src, src_it} to    |
// |            the free-list controller with a valid/ready handshake.        |
// | Ports    : clk, reset (async, active-high)                               |
// |            release_in / it_in   - per-lane request and iteration tag     |
// |            release_busy         - lane has a pending, ungranted request  |
// |            out_valid/out_ready  - head handshake                         |
// |            out_src / out_src_it - head lane index and tag                |
// |            fifo_count           - occupied FIFO entries                  |
// |            drop_err             - sticky, a request hit a busy lane      |
// | Config   : RELEASE_ROUND_ROBIN_EN selects rotating grant priority;       |
// |            undefined gives fixed lowest-index-first priority.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module freelist_release_queue #(
   parameter int WORD_WIDTH = 8,
   parameter int ITER_WIDTH = 9,
   parameter int STEP_RANGE = 128,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [STEP_RANGE-1:0]            release_in,
   input  logic [STEP_RANGE*ITER_WIDTH-1:0] it_in,
   output logic [STEP_RANGE-1:0]            release_busy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WORD_WIDTH-1:0]            out_src,
   output logic [ITER_WIDTH-1:0]            out_src_it,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
   output logic                             drop_err
);

   localparam int IDX_W = (STEP_RANGE > 1) ? $clog2(STEP_RANGE) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

   logic [STEP_RANGE-1:0] pending;
   logic [ITER_WIDTH-1:0] tag [STEP_RANGE];

   logic [IDX_W-1:0]      mem_src [FIFO_DEPTH];
   logic [ITER_WIDTH-1:0] mem_it  [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   logic                  pop;
   logic                  push;
   logic [IDX_W-1:0]      grant_idx;
   logic [PTR_W-1:0]      next_rd;
   logic [CNT_W-1:0]      next_count;
   logic                  head_from_push;

   assign release_busy = pending;
   assign out_valid    = (fifo_count != '0);
   assign pop          = out_valid & out_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push         = (|pending) & ((fifo_count != FULL_COUNT) | pop);

`ifdef RELEASE_ROUND_ROBIN_EN
   logic [IDX_W-1:0] last_grant;

   // Scan from farthest to nearest lane after last_grant so the nearest
   // pending lane (starting at last_grant+1, wrapping) is the final write.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] sel;
      grant_idx = '0;
      idx       = 0;
      sel       = '0;
      for (int k = STEP_RANGE - 1; k >= 0; k--) begin
         idx = int'(last_grant) + 1 + k;
         if (idx >= STEP_RANGE) idx = idx - STEP_RANGE;
         sel = IDX_W'(idx);
         if (pending[sel]) grant_idx = sel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     last_grant <= '0;
      else if (push) last_grant <= grant_idx;
   end
`else
   // Highest index first so the lowest pending lane is the final write.
   always_comb begin
      grant_idx = '0;
      for (int i = STEP_RANGE - 1; i >= 0; i--) begin
         if (pending[IDX_W'(i)]) grant_idx = IDX_W'(i);
      end
   end
`endif

   // Pending mask, tags and sticky drop flag. A request on a lane that is
   // already pending is dropped even if that lane is granted on this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         drop_err <= 1'b0;
         for (int i = 0; i < STEP_RANGE; i++) tag[i] <= '0;
      end else begin
         if (|(release_in & pending)) drop_err <= 1'b1;
         for (int i = 0; i < STEP_RANGE; i++) begin
            if (release_in[i] && !pending[i]) begin
               pending[i] <= 1'b1;
               tag[i]     <= it_in[i*ITER_WIDTH +: ITER_WIDTH];
            end else if (push && (grant_idx == IDX_W'(i))) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_src[wr_ptr] <= grant_idx;
         mem_it[wr_ptr]  <= tag[grant_idx];
      end
   end

   // The head after this edge is the entry being pushed exactly when it
   // lands in the slot the read pointer will point at.
   always_comb begin
      next_rd        = rd_ptr + PTR_W'(pop);
      next_count     = fifo_count + CNT_W'(push) - CNT_W'(pop);
      head_from_push = push && (wr_ptr == next_rd);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         out_src    <= '0;
         out_src_it <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr     <= next_rd;
         fifo_count <= next_count;
         // Head registers hold their last value once the FIFO drains.
         if (next_count != '0) begin
            if (head_from_push) begin
               out_src    <= WORD_WIDTH'(grant_idx);
               out_src_it <= tag[grant_idx];
            end else begin
               out_src    <= WORD_WIDTH'(mem_src[next_rd]);
               out_src_it <= mem_it[next_rd];
            end
         end
      end
   end

endmodule
`default_nettype wire
